spi_dac_seq: RTL and testbench

SPI_DAC_SEQ -- requirements
Module: spi_dac_seq

---
 rtl/spi_dac_pkg.sv | 38 +++
 rtl/spi_sck_tick.sv | 27 ++
 rtl/spi_dac_seq.sv | 190 +++++++++++++++++++
 tb/tb_spi_dac_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC sequencer: state codes, frame width,
// DAC command nibbles and the 32-bit frame builder.
package spi_dac_pkg;

  localparam int FRAME_W = 32;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_UPDATE_ALL   = 4'b0100;
  localparam logic [3:0] CMD_NOP          = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SCK_LO  = 3'd2,
    SCK_HI  = 3'd3,
    CS_HOLD = 3'd4,
    GAP     = 3'd5,
    CLR     = 3'd6,
    DONE    = 3'd7
  } state_e;

  // Plain-vector aliases of the state codes for the legacy-style state register.
  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_LOAD    = LOAD;
  localparam logic [2:0] ST_SCK_LO  = SCK_LO;
  localparam logic [2:0] ST_SCK_HI  = SCK_HI;
  localparam logic [2:0] ST_CS_HOLD = CS_HOLD;
  localparam logic [2:0] ST_GAP     = GAP;
  localparam logic [2:0] ST_CLR     = CLR;
  localparam logic [2:0] ST_DONE    = DONE;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                     input logic [3:0]  addr,
                                                     input logic [11:0] data);
    return {8'h00, cmd, addr, data, 4'h0};
  endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// Phase timer for the SPI clock: pulses o_tick on the last clk cycle of each
// CLK_DIV-long SCK half-period while enabled; idles at zero otherwise.
module spi_sck_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));

  // NOTE: registered state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dac_seq.sv
// Multi-channel SPI DAC sequencer: writes one 32-bit frame per enabled channel in
// ascending order, and issues DAC clear pulses on request (deferred while busy).
module spi_dac_seq
  import spi_dac_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 4,
  parameter int CLR_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [3:0]               cmd,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_cs,
  output logic                     spi_sck,
  output logic                     spi_mosi,
  output logic                     dac_clr
);

  localparam int CNT_MAX = (CS_GAP > CLR_CYCLES) ? CS_GAP : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]                r_state;
  logic [NUM_CH-1:0]         r_mask;
  logic [3:0]                r_cmd;
  logic [NUM_CH*DATA_W-1:0]  r_data;
  logic [FRAME_W-1:0]        r_shift;
  logic [4:0]                r_bit;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_clr_pend;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_cs;
  logic                      r_sck;
  logic                      r_mosi;
  logic                      r_clr;

  logic [2:0]                w_state_nxt;
  logic                      w_sck_en;
  logic                      w_tick;
  logic                      w_found;
  logic [3:0]                w_idx;
  logic [DATA_W-1:0]         w_sample;
  logic [11:0]               w_data12;
  logic [FRAME_W-1:0]        w_frame;
  logic                      w_in_frame_nxt;

  assign w_sck_en = (r_state == ST_SCK_LO) || (r_state == ST_SCK_HI);

  spi_sck_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_sck_en),
    .o_tick (w_tick)
  );

  // Lowest-numbered channel still pending; scanning downward lets the lowest hit win.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = 4'd0;
    w_sample = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_found  = 1'b1;
        w_idx    = 4'(i);
        w_sample = r_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_data12 = 12'(w_sample) << (12 - DATA_W);
  assign w_frame  = build_frame(r_cmd, w_idx, w_data12);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLR;
        end else if (start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:    w_state_nxt = w_found ? ST_SCK_LO : ST_DONE;
      ST_SCK_LO:  if (w_tick) w_state_nxt = ST_SCK_HI;
      ST_SCK_HI:  if (w_tick) w_state_nxt = (r_bit == 5'd31) ? ST_CS_HOLD : ST_SCK_LO;
      ST_CS_HOLD: w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (r_cnt == CNT_W'(CS_GAP - 1)) begin
          w_state_nxt = (|r_mask) ? ST_LOAD : ST_DONE;
        end
      end
      ST_CLR:     if (r_cnt == CNT_W'(CLR_CYCLES - 1)) w_state_nxt = ST_IDLE;
      ST_DONE:    w_state_nxt = (r_clr_pend || clr_req) ? ST_CLR : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_frame_nxt = (w_state_nxt == ST_SCK_LO) || (w_state_nxt == ST_SCK_HI) ||
                          (w_state_nxt == ST_CS_HOLD);

  // Outputs are registered from the next-state decode so pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_clr      <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      r_cs    <= !w_in_frame_nxt;
      r_sck   <= (w_state_nxt == ST_SCK_HI);
      r_clr   <= (w_state_nxt != ST_CLR);

      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_state == ST_GAP || r_state == ST_CLR) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A request arriving during a running clear merges into that pulse.
      if (r_state == ST_DONE) begin
        r_clr_pend <= 1'b0;
      end else if (clr_req && r_state != ST_IDLE && r_state != ST_CLR) begin
        r_clr_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_state_nxt == ST_LOAD) r_mask <= ch_mask;
        end
        ST_LOAD: begin
          if (w_found) begin
            r_mask <= r_mask & (r_mask - 1'b1);
            r_mosi <= w_frame[FRAME_W-1];
            r_bit  <= '0;
          end
        end
        ST_SCK_HI: begin
          if (w_tick && r_bit != 5'd31) begin
            r_bit  <= r_bit + 1'b1;
            r_mosi <= r_shift[FRAME_W-2];
          end
        end
        ST_CS_HOLD: r_mosi <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are always reloaded before being used.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_state_nxt == ST_LOAD) begin
      r_cmd  <= cmd;
      r_data <= ch_data;
    end
    if (r_state == ST_LOAD && w_found) begin
      r_shift <= w_frame;
    end else if (r_state == ST_SCK_HI && w_tick) begin
      r_shift <= r_shift << 1;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign dac_cs   = r_cs;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign dac_clr  = r_clr;

endmodule

// File: tb/tb_spi_dac_seq.sv
// Bench for spi_dac_seq: directed sequences push expected frames into per-DUT queues;
// a negedge monitor decodes MOSI frames, checks framing timing and pops/compares.
module tb_spi_dac_seq;
  import spi_dac_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int CS_GAP    = 4;
  localparam int FRAME_CYC = 64 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, clr_req = 1'b0;
  logic [3:0]  ch_mask = '0, cmd = '0;
  logic [47:0] ch_data = '0;
  logic        busy, done, dac_cs, spi_sck, spi_mosi, dac_clr;

  logic        start8 = 1'b0, clr8 = 1'b0;
  logic [1:0]  mask8 = '0;
  logic [3:0]  cmd8 = '0;
  logic [15:0] data8 = '0;
  logic        busy8, done8, dac_cs8, spi_sck8, spi_mosi8, dac_clr8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_dac_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .cmd(cmd), .ch_data(ch_data),
    .clr_req(clr_req), .busy(busy), .done(done), .dac_cs(dac_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .dac_clr(dac_clr)
  );

  spi_dac_seq #(.NUM_CH(2), .DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .ch_mask(mask8), .cmd(cmd8), .ch_data(data8),
    .clr_req(clr8), .busy(busy8), .done(done8), .dac_cs(dac_cs8), .spi_sck(spi_sck8),
    .spi_mosi(spi_mosi8), .dac_clr(dac_clr8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  cs_v, sck_v, mosi_v, busy_v, done_v;
  assign cs_v   = {dac_cs8, dac_cs};
  assign sck_v  = {spi_sck8, spi_sck};
  assign mosi_v = {spi_mosi8, spi_mosi};
  assign busy_v = {busy8, busy};
  assign done_v = {done8, done};

  logic [31:0] m_sh[2];
  int          m_bits[2], m_low[2], m_gap[2], n_done[2];
  logic        m_gap_v[2], m_bad[2], p_cs[2], p_sck[2], p_mosi[2];

  initial begin
    for (int d = 0; d < 2; d++) n_done[d] = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_bits[d]  <= 0;
        m_low[d]   <= 0;
        m_gap[d]   <= 0;
        m_gap_v[d] <= 1'b0;
        m_bad[d]   <= 1'b0;
        p_cs[d]    <= 1'b1;
        p_sck[d]   <= 1'b0;
        p_mosi[d]  <= 1'b0;
      end else begin
        if (done_v[d]) n_done[d] <= n_done[d] + 1;
        if (!cs_v[d]) begin
          if (p_cs[d]) begin
            if (m_gap_v[d]) check($sformatf("cs_gap%0d_ge4 (gap=%0d)", d, m_gap[d]),
                                  32'(m_gap[d] >= CS_GAP), 32'd1);
            m_low[d]  <= 1;
            m_bits[d] <= 0;
            m_bad[d]  <= 1'b0;
            m_sh[d]   <= '0;
          end else begin
            m_low[d] <= m_low[d] + 1;
          end
          if (sck_v[d] && !p_sck[d]) begin
            m_sh[d]   <= {m_sh[d][30:0], mosi_v[d]};
            m_bits[d] <= m_bits[d] + 1;
          end
          if (sck_v[d] && mosi_v[d] != p_mosi[d]) m_bad[d] <= 1'b1;
        end else begin
          if (!p_cs[d]) begin : frame_end
            automatic logic [31:0] exp_f = '0;
            automatic int qn = (d == 0) ? q0.size() : q1.size();
            check($sformatf("frame_pending%0d", d), 32'(qn > 0), 32'd1);
            if (qn > 0) begin
              exp_f = (d == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("frame_data%0d", d), m_sh[d], exp_f);
            end
            check($sformatf("frame_bits%0d", d), 32'(m_bits[d]), 32'd32);
            check($sformatf("frame_cs_low%0d", d), 32'(m_low[d]), 32'(FRAME_CYC));
            check($sformatf("mosi_stable%0d", d), 32'(m_bad[d]), 32'd0);
            m_gap[d]   <= 1;
            m_gap_v[d] <= 1'b1;
          end else begin
            m_gap[d] <= m_gap[d] + 1;
          end
          if (!busy_v[d]) m_gap_v[d] <= 1'b0;
        end
        p_cs[d]   <= cs_v[d];
        p_sck[d]  <= sck_v[d];
        p_mosi[d] <= mosi_v[d];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [3:0] m, input logic [3:0] c);
    ch_mask = m;
    cmd     = c;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (((d == 0) ? busy : busy8) && n < budget) begin
      step(1);
      n++;
    end
    check($sformatf("idle_reached%0d", d), 32'((d == 0) ? busy : busy8), 32'd0);
    check($sformatf("frames_left%0d", d), 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, n, rises;
    logic bad, prev, seen;

    // Reset state: {busy,done,cs,sck,mosi,clr}
    rst = 1'b1;
    step(2);
    check("reset_outs", 32'({busy, done, dac_cs, spi_sck, spi_mosi, dac_clr}), 32'b001001);
    check("reset_outs8", 32'({busy8, done8, dac_cs8, spi_sck8, spi_mosi8, dac_clr8}), 32'b001001);
    rst = 1'b0;
    step(2);

    // Single channel 2 frame, plus start-to-cs latency.
    ch_data = '0;
    ch_data[2*12 +: 12] = 12'hABC;
    q0.push_back(32'h0032ABC0);
    snap = n_done[0];
    pulse_start(4'b0100, CMD_WRITE_UPDATE);
    check("lat_load_busy_cs", 32'({busy, dac_cs}), 32'b11);
    step(1);
    check("lat_cs_low", 32'(dac_cs), 32'd0);
    wait_idle(0, 1000);
    check("done_once_ch2", 32'(n_done[0] - snap), 32'd1);

    // Two channels, ascending order, CS gap checked by the monitor.
    ch_data = '0;
    ch_data[0 +: 12]    = 12'h001;
    ch_data[2*12 +: 12] = 12'hFFF;
    q0.push_back(32'h00300010);
    q0.push_back(32'h0032FFF0);
    snap = n_done[0];
    pulse_start(4'b0101, CMD_WRITE_UPDATE);
    wait_idle(0, 1000);
    check("done_once_2ch", 32'(n_done[0] - snap), 32'd1);

    // Inputs changed after acceptance and a second start mid-sequence are ignored.
    ch_data = '0;
    ch_data[0 +: 12]  = 12'h123;
    ch_data[12 +: 12] = 12'h456;
    q0.push_back(32'h00401230);
    q0.push_back(32'h00414560);
    snap = n_done[0];
    pulse_start(4'b0011, CMD_UPDATE_ALL);
    ch_data = 48'hFEDCBA987654;
    cmd     = CMD_NOP;
    ch_mask = 4'b1111;
    step(60);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle(0, 1000);
    check("done_once_capture", 32'(n_done[0] - snap), 32'd1);

    // Clear requests (two, merged) during frame 1 of 2: serviced after DONE.
    ch_data = '0;
    ch_data[0 +: 12]  = 12'h0AA;
    ch_data[12 +: 12] = 12'h055;
    q0.push_back(32'h00300AA0);
    q0.push_back(32'h00310550);
    snap = n_done[0];
    pulse_start(4'b0011, CMD_WRITE_UPDATE);
    step(20);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    step(30);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      step(1);
      n++;
    end
    check("clr_seq_done_seen", 32'(done), 32'd1);
    check("clr_high_at_done", 32'(dac_clr), 32'd1);
    step(1);
    n = 0;
    bad = 1'b0;
    while (!dac_clr && n < 50) begin
      if (!busy) bad = 1'b1;
      n++;
      step(1);
    end
    check("clr_pulse_len", 32'(n), 32'd8);
    check("clr_busy_during", 32'(bad), 32'd0);
    check("clr_busy_after", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!dac_clr) seen = 1'b1;
    end
    check("clr_merged_single", 32'(seen), 32'd0);
    check("done_once_clr", 32'(n_done[0] - snap), 32'd1);
    check("frames_left_clr", 32'(q0.size()), 32'd0);

    // clr_req and start together in IDLE: clear wins, start dropped, start in CLR ignored.
    ch_data = '0;
    ch_data[0 +: 12] = 12'h777;
    ch_mask = 4'b0001;
    clr_req = 1'b1;
    start   = 1'b1;
    step(1);
    clr_req = 1'b0;
    start   = 1'b0;
    check("clr_idle_first", 32'({dac_clr, busy}), 32'b01);
    n = 0;
    bad = 1'b0;
    while (!dac_clr && n < 50) begin
      start = (n == 2);
      if (!busy) bad = 1'b1;
      n++;
      step(1);
    end
    start = 1'b0;
    check("clr_idle_len", 32'(n), 32'd8);
    check("clr_idle_busy", 32'(bad), 32'd0);
    check("clr_idle_busy_after", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (!dac_cs || busy) seen = 1'b1;
    end
    check("start_dropped_no_frame", 32'(seen), 32'd0);

    // Reset during bit 15: frame aborted, no done; a fresh frame afterwards is intact.
    ch_data = '0;
    ch_data[0 +: 12] = 12'h9E1;
    snap  = n_done[0];
    pulse_start(4'b0001, CMD_WRITE_UPDATE);
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 400 && !(rises == 16 && !spi_sck); i++) begin
      step(1);
      if (spi_sck && !prev) rises++;
      prev = spi_sck;
    end
    check("rst_reached_bit15", 32'(rises), 32'd16);
    check("rst_cs_low_before", 32'(dac_cs), 32'd0);
    rst = 1'b1;
    step(1);
    check("rst_mid_outs", 32'({busy, done, dac_cs, spi_sck, spi_mosi, dac_clr}), 32'b001001);
    rst = 1'b0;
    step(5);
    check("rst_no_done", 32'(n_done[0] - snap), 32'd0);
    ch_data = '0;
    ch_data[12 +: 12] = 12'h3C5;
    q0.push_back(32'h00313C50);
    snap = n_done[0];
    pulse_start(4'b0010, CMD_WRITE_UPDATE);
    wait_idle(0, 1000);
    check("done_once_after_rst", 32'(n_done[0] - snap), 32'd1);

    // 8-bit DAC instance: left-justified data, then an empty mask.
    data8 = 16'h005A;
    cmd8  = CMD_WRITE_UPDATE;
    mask8 = 2'b01;
    q1.push_back(32'h00305A00);
    snap  = n_done[1];
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    wait_idle(1, 1000);
    check("done_once_dw8", 32'(n_done[1] - snap), 32'd1);

    mask8 = 2'b00;
    seen  = 1'b0;
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    if (!dac_cs8) seen = 1'b1;
    check("mask0_cyc1", 32'({busy8, done8}), 32'b10);
    step(1);
    if (!dac_cs8) seen = 1'b1;
    check("mask0_cyc2", 32'({busy8, done8}), 32'b11);
    step(1);
    if (!dac_cs8) seen = 1'b1;
    check("mask0_cyc3", 32'({busy8, done8}), 32'b00);
    check("mask0_no_cs", 32'(seen), 32'd0);

    step(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
